obstacle_lane_engine: RTL and testbench
=======================================

OBSTACLE_LANE_ENGINE -- requirements
Module: obstacle_lane_engine

Interface
REQ-001 Parameter NUM_OBS, 4, number of obstacle channels (1..8).
REQ-002 Parameter XW, 11, x-coordinate width.
REQ-003 Parameter SPAWN_X, 1280, x loaded on spawn.
REQ-004 Parameter MIN_GAP, 200, minimum scrolled pixels between consecutive spawns.
REQ-005 Parameter RAMP_COUNT, 12, obstacles passed per speed increment.
REQ-006 Parameter MAX_SPEED, 8, speed ceiling (pixels/frame).
REQ-007 Parameter POWER_FRAMES, 300, power-mode duration in frames.
REQ-008 Parameters OBS_Y 248, OBS_W 32, OBS_H 32, DINO_W 32, DINO_H 32: fixed box geometry.
REQ-009 clk  in  1  system clock; reset reset, asynchronous, active-high; clock clk.
REQ-010 reset  in  1  asynchronous active-high reset.
REQ-011 frame_tick  in  1  one-cycle pulse per video frame.
REQ-012 start  in  1  level; begins/restarts a game.
REQ-013 power_pickup  in  1  one-cycle pulse; power-up collected.
REQ-014 dino_x, dino_y  in  XW each  dino box top-left.
REQ-015 obs_x  out  NUM_OBS*XW  packed obstacle x, channel i at [i*XW +: XW].
REQ-016 obs_active  out  NUM_OBS  channel valid.
REQ-017 obs_kind  out  2*NUM_OBS  sprite kind per channel.
REQ-018 speed  out  4  current scroll speed.
REQ-019 powered  out  1  power mode active.
REQ-020 game_over  out  1  high in OVER state.
REQ-021 score  out  16  obstacles cleared.

Function
REQ-022 FSM states IDLE, PLAY, OVER; IDLE->PLAY and OVER->PLAY on start=1; PLAY->OVER on unpowered collision; no other transitions.
REQ-023 Entering PLAY: all channels inactive, x=SPAWN_X, speed=1, score=0, passed=0, powered=0, gap counter=MIN_GAP.
REQ-024 8-bit LFSR x^8+x^6+x^5+x^4+1, seed 8'hAC, advances every clk in all states.
REQ-025 Motion only on frame_tick in PLAY; active channel with x<=speed becomes inactive, score+1 (saturate 16'hFFFF), passed+1; else x-=speed.
REQ-026 gap counter += speed per frame_tick, saturating at MIN_GAP.
REQ-027 Spawn on frame_tick when gap counter>=MIN_GAP, some channel inactive, lfsr[0]=1: lowest-index inactive channel (post-move) gets x=SPAWN_X, kind=lfsr[2:1], active=1; gap counter cleared; max one spawn per tick.
REQ-028 passed reaching RAMP_COUNT: speed+1 saturating at MAX_SPEED, passed=0, same tick.
REQ-029 Collision evaluated every clk in PLAY, registered outputs, strict AABB overlap (dino box vs OBS_Y/OBS_W/OBS_H box); touching edges do not collide.
REQ-030 Unpowered collision: game_over=1 next cycle; positions frozen thereafter.
REQ-031 Powered collision: colliding channels deactivated, score+1 each, no state change.
REQ-032 power_pickup in PLAY: powered=1, counter=POWER_FRAMES (re-pickup reloads); counter decrements per frame_tick; powered clears on tick where counter reaches 0.
REQ-033 power_pickup and collision same cycle: pickup wins, collision treated as powered.
REQ-034 power_pickup ignored outside PLAY.
REQ-035 start held in PLAY has no effect.
REQ-036 Latency: frame_tick to updated obs_x = 1 clk.

Reset
REQ-037 Async reset: state IDLE, obs_active=0, obs_x=SPAWN_X all, obs_kind=0, speed=1, powered=0, game_over=0, score=0, LFSR=8'hAC.
REQ-038 Reset mid-PLAY returns all outputs to REQ-037 values within the same cycle; no spawn occurs until start.

Verification
REQ-039 Reset, start, 1 tick with lfsr[0]=1 -> channel 0 active, x=1280; next tick x=1279.
REQ-040 Force 12 obstacles past x<=speed -> score=12, speed=2; continue to speed 8 -> saturates at 8.
REQ-041 Place dino_x=100, dino_y=248, obstacle reaching x=131 -> collision, game_over=1 next cycle; x=132 -> no collision.
REQ-042 power_pickup then collision -> channel deactivated, score+1, game_over=0; after 300 ticks powered=0.
REQ-043 All NUM_OBS channels active -> no spawn; one clears -> that index reused after MIN_GAP.
REQ-044 Assert reset mid-PLAY with 3 active channels -> all outputs at reset values immediately; start restarts cleanly.

Source files
------------

// File: rtl/obstacle_lane_engine.sv
// Obstacle lane engine for a side-scrolling runner: spawns obstacles into a
// fixed pool of channels, scrolls them once per frame, ramps the scroll speed,
// tracks score and power mode, and detects dino/obstacle collisions.
module obstacle_lane_engine #(
  parameter int NUM_OBS      = 4,
  parameter int XW           = 11,
  parameter int SPAWN_X      = 1280,
  parameter int MIN_GAP      = 200,
  parameter int RAMP_COUNT   = 12,
  parameter int MAX_SPEED    = 8,
  parameter int POWER_FRAMES = 300,
  parameter int OBS_Y        = 248,
  parameter int OBS_W        = 32,
  parameter int OBS_H        = 32,
  parameter int DINO_W       = 32,
  parameter int DINO_H       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   start,
  input  logic                   power_pickup,
  input  logic [XW-1:0]          dino_x,
  input  logic [XW-1:0]          dino_y,
  output logic [NUM_OBS*XW-1:0]  obs_x,
  output logic [NUM_OBS-1:0]     obs_active,
  output logic [2*NUM_OBS-1:0]   obs_kind,
  output logic [3:0]             speed,
  output logic                   powered,
  output logic                   game_over,
  output logic [15:0]            score
);

  localparam int GW = $clog2(MIN_GAP + MAX_SPEED + 1);
  localparam int PW = $clog2(RAMP_COUNT + NUM_OBS + 1);
  localparam int CW = $clog2(POWER_FRAMES + 1);
  localparam int NW = $clog2(2 * NUM_OBS + 1);

  localparam logic [XW-1:0] SPAWN_XV  = XW'(SPAWN_X);
  localparam logic [GW-1:0] GAP_MAX   = GW'(MIN_GAP);
  localparam logic [PW-1:0] RAMP_V    = PW'(RAMP_COUNT);
  localparam logic [3:0]    SPEED_MAX = 4'(MAX_SPEED);
  localparam logic [CW-1:0] PWR_V     = CW'(POWER_FRAMES);
  // Geometry carried one bit wider so right/bottom edges never wrap.
  localparam logic [XW:0]   OBS_Y_LO  = (XW+1)'(OBS_Y);
  localparam logic [XW:0]   OBS_Y_HI  = (XW+1)'(OBS_Y + OBS_H);
  localparam logic [XW:0]   OBS_WV    = (XW+1)'(OBS_W);
  localparam logic [XW:0]   DINO_WV   = (XW+1)'(DINO_W);
  localparam logic [XW:0]   DINO_HV   = (XW+1)'(DINO_H);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t             state_q, state_d;
  logic [7:0]         lfsr_q;
  logic [XW-1:0]      x_q    [NUM_OBS];
  logic [XW-1:0]      x_d    [NUM_OBS];
  logic [1:0]         kind_q [NUM_OBS];
  logic [1:0]         kind_d [NUM_OBS];
  logic [NUM_OBS-1:0] act_q, act_d;
  logic [3:0]         speed_q, speed_d;
  logic [15:0]        score_q, score_d;
  logic [PW-1:0]      passed_q, passed_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [CW-1:0]      pcnt_q, pcnt_d;
  logic               pow_q, pow_d;

  logic [NUM_OBS-1:0] hit;
  logic [XW-1:0]      speed_x;
  logic [NW-1:0]      gain;
  logic [NW-1:0]      n_pass;
  logic [PW-1:0]      passed_sum;
  logic [GW-1:0]      gap_sum, gap_sat;
  logic [16:0]        score_sum;
  logic               found;

  // Strict AABB overlap of the dino box against every active obstacle box.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      hit[i] = (state_q == PLAY) && act_q[i]
            && ({1'b0, dino_x} < {1'b0, x_q[i]} + OBS_WV)
            && ({1'b0, x_q[i]} < {1'b0, dino_x} + DINO_WV)
            && ({1'b0, dino_y} < OBS_Y_HI)
            && (OBS_Y_LO < {1'b0, dino_y} + DINO_HV);
    end
  end

  // Next-state logic: game FSM, motion, spawning, ramp, score and power timer.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    x_d        = x_q;
    kind_d     = kind_q;
    act_d      = act_q;
    speed_d    = speed_q;
    score_d    = score_q;
    passed_d   = passed_q;
    gap_d      = gap_q;
    pcnt_d     = pcnt_q;
    pow_d      = pow_q;
    speed_x    = XW'(speed_q);
    gain       = '0;
    n_pass     = '0;
    passed_sum = passed_q;
    gap_sum    = gap_q + GW'(speed_q);
    gap_sat    = (gap_sum > GAP_MAX) ? GAP_MAX : gap_sum;
    score_sum  = {1'b0, score_q};
    found      = 1'b0;

    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d  = PLAY;
          for (int i = 0; i < NUM_OBS; i++) x_d[i] = SPAWN_XV;
          act_d    = '0;
          speed_d  = 4'd1;
          score_d  = '0;
          passed_d = '0;
          pow_d    = 1'b0;
          pcnt_d   = '0;
          gap_d    = GAP_MAX;
        end
      end
      PLAY: begin
        if (|hit && !(pow_q || power_pickup)) begin
          // Unpowered hit ends the game; everything else stays frozen.
          state_d = OVER;
        end else begin
          // Powered hits destroy the obstacle and count as cleared.
          for (int i = 0; i < NUM_OBS; i++) begin
            if (hit[i]) begin
              act_d[i] = 1'b0;
              gain     = gain + NW'(1);
            end
          end
          // A fresh pickup reloads the timer and wins over a same-tick expiry.
          if (power_pickup) begin
            pow_d  = 1'b1;
            pcnt_d = PWR_V;
          end else if (frame_tick && pow_q) begin
            pcnt_d = pcnt_q - CW'(1);
            if (pcnt_q == CW'(1)) pow_d = 1'b0;
          end
          if (frame_tick) begin
            for (int i = 0; i < NUM_OBS; i++) begin
              if (act_q[i] && !hit[i]) begin
                if (x_q[i] <= speed_x) begin
                  act_d[i] = 1'b0;
                  n_pass   = n_pass + NW'(1);
                end else begin
                  x_d[i] = x_q[i] - speed_x;
                end
              end
            end
            gain       = gain + n_pass;
            passed_sum = passed_q + PW'(n_pass);
            if (passed_sum >= RAMP_V) begin
              passed_d = '0;
              if (speed_q < SPEED_MAX) speed_d = speed_q + 4'd1;
            end else begin
              passed_d = passed_sum;
            end
            gap_d = gap_sat;
            // Spawn into the lowest free channel after this tick's motion.
            if (gap_sat >= GAP_MAX && lfsr_q[0]) begin
              for (int i = 0; i < NUM_OBS; i++) begin
                if (!found && !act_d[i]) begin
                  found     = 1'b1;
                  act_d[i]  = 1'b1;
                  x_d[i]    = SPAWN_XV;
                  kind_d[i] = lfsr_q[2:1];
                end
              end
              if (found) gap_d = '0;
            end
          end
          score_sum = {1'b0, score_q} + 17'(gain);
          score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Game state registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      act_q    <= '0;
      speed_q  <= 4'd1;
      score_q  <= '0;
      passed_q <= '0;
      gap_q    <= GAP_MAX;
      pcnt_q   <= '0;
      pow_q    <= 1'b0;
      // NOTE: the channel arrays are a handful of flops, not RAM, so they are reset.
      for (int i = 0; i < NUM_OBS; i++) begin
        x_q[i]    <= SPAWN_XV;
        kind_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      speed_q  <= speed_d;
      score_q  <= score_d;
      passed_q <= passed_d;
      gap_q    <= gap_d;
      pcnt_q   <= pcnt_d;
      pow_q    <= pow_d;
      x_q      <= x_d;
      kind_q   <= kind_d;
    end
  end

  // Free-running LFSR x^8+x^6+x^5+x^4+1, advancing every clock in all states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 8'hAC;
    else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Pack channel state onto the output buses.
  always_comb begin
    obs_x    = '0;
    obs_kind = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      obs_x[i*XW +: XW]  = x_q[i];
      obs_kind[2*i +: 2] = kind_q[i];
    end
  end

  assign obs_active = act_q;
  assign speed      = speed_q;
  assign score      = score_q;
  assign powered    = pow_q;
  assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_obstacle_lane_engine.sv
// Scoreboard bench for obstacle_lane_engine: a behavioural game model predicts
// every cycle's outputs, and a monitor compares them against the DUT.
module tb_obstacle_lane_engine;

  localparam int NUM_OBS      = 4;
  localparam int XW           = 11;
  localparam int SPAWN_X      = 1280;
  localparam int MIN_GAP      = 200;
  localparam int RAMP_COUNT   = 12;
  localparam int MAX_SPEED    = 8;
  localparam int POWER_FRAMES = 300;
  localparam int OBS_Y        = 248;
  localparam int OBS_W        = 32;
  localparam int OBS_H        = 32;
  localparam int DINO_W       = 32;
  localparam int DINO_H       = 32;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_OVER = 2;

  logic                  clk          = 1'b0;
  logic                  reset        = 1'b0;
  logic                  frame_tick   = 1'b0;
  logic                  start        = 1'b0;
  logic                  power_pickup = 1'b0;
  logic [XW-1:0]         dino_x       = '0;
  logic [XW-1:0]         dino_y       = '0;
  logic [NUM_OBS*XW-1:0] obs_x;
  logic [NUM_OBS-1:0]    obs_active;
  logic [2*NUM_OBS-1:0]  obs_kind;
  logic [3:0]            speed;
  logic                  powered;
  logic                  game_over;
  logic [15:0]           score;

  obstacle_lane_engine dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .start        (start),
    .power_pickup (power_pickup),
    .dino_x       (dino_x),
    .dino_y       (dino_y),
    .obs_x        (obs_x),
    .obs_active   (obs_active),
    .obs_kind     (obs_kind),
    .speed        (speed),
    .powered      (powered),
    .game_over    (game_over),
    .score        (score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_OBS*XW-1:0] x;
    logic [NUM_OBS-1:0]    act;
    logic [2*NUM_OBS-1:0]  kind;
    logic [3:0]            speed;
    logic                  powered;
    logic                  over;
    logic [15:0]           score;
  } snap_t;

  snap_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  // Behavioural game model.
  int       m_x    [NUM_OBS];
  bit       m_act  [NUM_OBS];
  int       m_kind [NUM_OBS];
  int       m_speed, m_score, m_passed, m_gap, m_pcnt, m_mode;
  bit       m_pow;
  bit [7:0] m_lfsr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit boxes_overlap(int ax, int ay, int aw, int ah,
                                       int bx, int by, int bw, int bh);
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE;
    foreach (m_x[i]) begin
      m_x[i] = SPAWN_X; m_act[i] = 0; m_kind[i] = 0;
    end
    m_speed = 1; m_score = 0; m_passed = 0; m_gap = MIN_GAP;
    m_pcnt = 0; m_pow = 0; m_lfsr = 8'hAC;
  endfunction

  function automatic bit model_would_hit(int dx, int dy);
    bit h = 0;
    if (m_mode == M_PLAY)
      foreach (m_x[i])
        if (m_act[i] && boxes_overlap(dx, dy, DINO_W, DINO_H, m_x[i], OBS_Y, OBS_W, OBS_H)) h = 1;
    return h;
  endfunction

  function automatic void model_step(bit tick, bit st, bit pick, int dx, int dy);
    bit hit [NUM_OBS];
    bit any_hit = 0;
    int gain = 0;
    int passes = 0;
    int slot = -1;
    if (m_mode != M_PLAY) begin
      if (st) begin
        m_mode = M_PLAY;
        foreach (m_x[i]) begin m_x[i] = SPAWN_X; m_act[i] = 0; end
        m_speed = 1; m_score = 0; m_passed = 0; m_pow = 0; m_pcnt = 0; m_gap = MIN_GAP;
      end
    end else begin
      foreach (hit[i]) begin
        hit[i] = m_act[i] && boxes_overlap(dx, dy, DINO_W, DINO_H, m_x[i], OBS_Y, OBS_W, OBS_H);
        any_hit |= hit[i];
      end
      if (any_hit && !(m_pow || pick)) begin
        m_mode = M_OVER;
      end else begin
        foreach (hit[i]) if (hit[i]) begin m_act[i] = 0; gain++; end
        if (pick) begin
          m_pow = 1; m_pcnt = POWER_FRAMES;
        end else if (tick && m_pow) begin
          m_pcnt--;
          if (m_pcnt == 0) m_pow = 0;
        end
        if (tick) begin
          m_gap = (m_gap + m_speed > MIN_GAP) ? MIN_GAP : m_gap + m_speed;
          foreach (m_x[i]) begin
            if (m_act[i]) begin
              if (m_x[i] <= m_speed) begin m_act[i] = 0; passes++; end
              else m_x[i] -= m_speed;
            end
          end
          gain += passes;
          m_passed += passes;
          if (m_passed >= RAMP_COUNT) begin
            m_passed = 0;
            if (m_speed < MAX_SPEED) m_speed++;
          end
          foreach (m_act[i]) if (!m_act[i] && slot < 0) slot = i;
          if (m_gap >= MIN_GAP && m_lfsr[0] && slot >= 0) begin
            m_x[slot] = SPAWN_X; m_act[slot] = 1; m_kind[slot] = int'(m_lfsr[2:1]); m_gap = 0;
          end
        end
        m_score = (m_score + gain > 65535) ? 65535 : m_score + gain;
      end
    end
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endfunction

  function automatic snap_t snap();
    snap_t s;
    s = '0;
    foreach (m_x[i]) begin
      s.x[i*XW +: XW]  = XW'(m_x[i]);
      s.act[i]         = m_act[i];
      s.kind[2*i +: 2] = 2'(m_kind[i]);
    end
    s.speed   = 4'(m_speed);
    s.powered = m_pow;
    s.over    = (m_mode == M_OVER);
    s.score   = 16'(m_score);
    return s;
  endfunction

  function automatic int n_active();
    int n = 0;
    foreach (m_act[i]) n += int'(m_act[i]);
    return n;
  endfunction

  function automatic int dut_x(int i);
    return int'(obs_x[i*XW +: XW]);
  endfunction

  // One clock of stimulus: drive at the falling edge, predict, queue expectation.
  task automatic cycle(input bit rst, input bit tick, input bit st, input bit pick,
                       input int dx, input int dy);
    @(negedge clk);
    if (rst && !reset) begin
      model_reset();
      exp_q.push_back(snap());
    end
    reset = rst; frame_tick = tick; start = st; power_pickup = pick;
    dino_x = XW'(dx); dino_y = XW'(dy);
    if (rst) model_reset();
    else     model_step(tick, st, pick, dx, dy);
    exp_q.push_back(snap());
    @(posedge clk);
    #2;
  endtask

  // Monitor: after every clock edge or reset assertion, compare against the queue.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("obs_x",      64'(obs_x),      64'(e.x));
        check("obs_active", 64'(obs_active), 64'(e.act));
        check("obs_kind",   64'(obs_kind),   64'(e.kind));
        check("speed",      64'(speed),      64'(e.speed));
        check("powered",    64'(powered),    64'(e.powered));
        check("game_over",  64'(game_over),  64'(e.over));
        check("score",      64'(score),      64'(e.score));
      end
    end
  end

  // Stimulus.
  initial begin
    int  k;
    int  prev;
    bit  seen12;
    bit  seen_hit;
    bit  rst_r;
    model_reset();

    // Reset and first spawn.
    repeat (3) cycle(1, 0, 0, 0, 0, 0);
    check("reset_speed", 64'(speed), 64'(1));
    check("reset_obs_x", 64'(obs_x), {20'd0, {NUM_OBS{11'd1280}}});
    cycle(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20 && !m_lfsr[0]; i++) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    check("first_spawn_active", 64'(obs_active[0]), 64'(1));
    check("first_spawn_x", 64'(dut_x(0)), 64'(1280));
    cycle(0, 1, 0, 0, 0, 0);
    check("first_move_x", 64'(dut_x(0)), 64'(1279));

    // Speed ramp to saturation, dino out of the lane; start held briefly in PLAY.
    seen12 = 0;
    k = 0;
    for (int c = 0; c < 30000 && k < 400; c++) begin
      cycle(0, 1, (c < 5), 0, 0, 0);
      if (!seen12 && m_score == 12) begin
        seen12 = 1;
        check("ramp_score12", 64'(score), 64'(12));
        check("ramp_speed2", 64'(speed), 64'(2));
      end
      if (m_speed == MAX_SPEED) k++;
    end
    check("ramp_speed_sat", 64'(speed), 64'(MAX_SPEED));

    // Unpowered collision at speed 8, then a restart and a speed-1 edge collision.
    for (int c = 0; c < 3000 && m_mode == M_PLAY; c++) cycle(0, 1, 0, 0, 100, 248);
    check("over_fast", 64'(game_over), 64'(1));
    repeat (4) cycle(0, 1, 0, 0, 100, 248);
    cycle(0, 0, 1, 0, 100, 248);
    for (int c = 0; c < 3000 && m_mode == M_PLAY; c++) cycle(0, 1, 0, 0, 100, 248);
    check("over_edge", 64'(game_over), 64'(1));
    check("over_edge_x", 64'(dut_x(0)), 64'(131));
    repeat (3) cycle(0, 1, 0, 0, 100, 248);
    check("frozen_x", 64'(dut_x(0)), 64'(131));

    // Powered collisions and power expiry.
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 1200, 248);
    k = 0;
    seen_hit = 0;
    for (int c = 0; c < 2000 && k < POWER_FRAMES; c++) begin
      prev = m_score;
      cycle(0, 1, 0, 0, 1200, 248);
      k++;
      if (!seen_hit && prev == 0 && m_score == 1) begin
        seen_hit = 1;
        check("pow_hit_over", 64'(game_over), 64'(0));
        check("pow_hit_score", 64'(score), 64'(1));
        check("pow_hit_active0", 64'(obs_active[0]), 64'(0));
      end
      if (k == POWER_FRAMES - 1) check("pow_still_on", 64'(powered), 64'(1));
    end
    check("pow_expired", 64'(powered), 64'(0));
    // Pickup on the very cycle of a collision counts as powered.
    for (int c = 0; c < 3000 && m_mode == M_PLAY && !model_would_hit(1200, 248); c++)
      cycle(0, 1, 0, 0, 1200, 248);
    cycle(0, 1, 0, 1, 1200, 248);
    check("pickup_wins_over", 64'(game_over), 64'(0));
    check("pickup_wins_pow", 64'(powered), 64'(1));

    // Fill three channels, then reset mid-play and restart.
    for (int c = 0; c < 6000 && n_active() < 3; c++) cycle(0, 1, 1, 0, 0, 0);
    check("three_active", 64'(obs_active[2:0]), 64'(3'b111));
    @(negedge clk);
    model_reset();
    exp_q.push_back(snap());
    reset = 1'b1;
    #1;
    check("midreset_active", 64'(obs_active), 64'(0));
    check("midreset_score", 64'(score), 64'(0));
    check("midreset_over", 64'(game_over), 64'(0));
    exp_q.push_back(snap());
    @(posedge clk);
    #2;
    repeat (2) cycle(1, 1, 0, 0, 0, 0);
    repeat (20) cycle(0, 1, 0, 1, 0, 0);
    check("idle_no_spawn", 64'(obs_active), 64'(0));
    cycle(0, 0, 1, 0, 0, 0);
    repeat (300) cycle(0, 1, 0, 0, 0, 0);

    // Randomized play.
    for (int c = 0; c < 5000; c++) begin
      int dy_sel;
      int dy;
      dy_sel = int'($urandom_range(0, 5));
      case (dy_sel)
        0: dy = 0;
        1: dy = 216;
        2: dy = 217;
        3: dy = 248;
        4: dy = 279;
        default: dy = int'($urandom_range(0, 2047));
      endcase
      rst_r = ($urandom_range(0, 999) < 2);
      cycle(rst_r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) < 2),
            ($urandom_range(0, 199) < 2), int'($urandom_range(0, 1400)), dy);
    end

    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
